div_share_ctrl: RTL and testbench

Round-robin scheduler that shares one `div32` pipelined divider among NREQ requesters. Arbitrates one division per cycle into the divider and tracks each in-flight operation with a tag pipeline matched to the divider latency. Returns each quotient with the originating requester ID. Sits between the compute clients and the single `div32` instance.

---
 rtl/div_share_pkg.sv | 16 +
 rtl/div_share_ctrl_if.sv | 31 +++
 rtl/div_share_ctrl_rr_arb.sv | 51 +++++
 rtl/div_share_ctrl.sv | 120 ++++++++++++
 tb/tb_div_share_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_share_pkg.sv
// Shared types and constants for the divider-sharing controller.
package div_share_pkg;

    localparam int DATA_W  = 32;
    localparam int DIV_LAT = 32;

    // Tag id field is sized for the largest supported requester count (8).
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic               v;
        logic [TAG_IDW-1:0] id;
        logic               dbz;
    } div_tag_t;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Requester-side request/response bundle of the divider-sharing controller.
interface div_share_ctrl_if
    import div_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W*NREQ-1:0] req_a;
    logic [DATA_W*NREQ-1:0] req_b;

    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [DATA_W-1:0]      rsp_q;
    logic                   rsp_dbz;

    // Requester side
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_dbz
    );

    // Controller side
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_dbz
    );

endinterface

// File: rtl/div_share_ctrl_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the
// priority pointer; the pointer moves past the grantee when en is high.
module rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt_ptr;
    logic [PW-1:0] idx;
    int            idx_i;
    logic          found;

    // Select the first valid requester at or after the pointer; no grant in reset
    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        idx_i   = 0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_i = (int'(ptr) + i) % N;
            idx   = PW'(idx_i);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt_ptr  = PW'((idx_i + 1) % N);
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    // Priority pointer: restarts at requester 0, advances after each grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= nxt_ptr;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one pipelined div32 among NREQ requesters: round-robin issue of one
// division per cycle, a tag pipeline matched to the divider latency, and a
// registered response carrying the requester id.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DIV_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    div_share_ctrl_if.slave   bus,
    output logic [5:0]        inflight,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic [DATA_W-1:0] div_q
);

    logic [NREQ-1:0]   gnt;
    logic              xfer;
    logic [IDW-1:0]    gnt_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    div_tag_t tag_p0;
    div_tag_t tag_pipe [DIV_LAT];
    div_tag_t tag_out;

    // A zero divisor yields an all-ones quotient regardless of the divider output
    function automatic logic [DATA_W-1:0] sat_dbz(input logic [DATA_W-1:0] q,
                                                  input logic              dbz);
        return dbz ? '1 : q;
    endfunction

    rr_arb #(.N(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req_valid),
        .en  (xfer),
        .gnt (gnt)
    );

    assign bus.req_ready = gnt;
    assign xfer          = |gnt;
    assign tag_out       = tag_pipe[DIV_LAT-1];

    // Encode the grantee and mux its operands
    always_comb begin
        gnt_id = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
                sel_a  = bus.req_a[i*DATA_W +: DATA_W];
                sel_b  = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Issue stage: operands to div32 plus the tag; operands hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            div_a  <= '0;
            div_b  <= '0;
            tag_p0 <= '0;
        end else begin
            tag_p0.v <= xfer;
            if (xfer) begin
                div_a      <= sel_a;
                div_b      <= sel_b;
                tag_p0.id  <= TAG_IDW'(gnt_id);
                tag_p0.dbz <= (sel_b == '0);
            end
        end
    end

    // Tag pipeline: free-running, aligned with div32 latency; reset drops all tags
    always_ff @(posedge clk) begin
        tag_pipe[0] <= tag_p0;
        for (int k = 1; k < DIV_LAT; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
        end
        if (rst) begin
            for (int k = 0; k < DIV_LAT; k++) begin
                tag_pipe[k].v <= 1'b0;
            end
        end
    end

    // Response stage: one-cycle pulse, all fields zero when no result
    always_ff @(posedge clk) begin
        if (rst || !tag_out.v) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_q     <= '0;
            bus.rsp_dbz   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= IDW'(tag_out.id);
            bus.rsp_q     <= sat_dbz(div_q, tag_out.dbz);
            bus.rsp_dbz   <= tag_out.dbz;
        end
    end

    // Outstanding-operation count: up on issue, down on response
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({xfer, bus.rsp_valid})
                2'b10:   inflight <= inflight + 6'd1;
                2'b01:   inflight <= inflight - 6'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural 32-stage divider.
module tb_div_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 32;

    typedef struct {
        int          id;
        logic [31:0] q;
        logic        dbz;
        int          edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  inflight;
    logic [31:0] div_a, div_b, div_q;
    logic [31:0] qpipe [LAT];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];
    exp_t e_pop, e_push;

    div_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    div_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .DIV_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .inflight (inflight),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_q    (div_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural div32: quotient appears LAT edges after the operand register
    always @(posedge clk) begin
        qpipe[0] <= (div_b == 32'd0) ? 32'h1234_5678 : div_a / div_b;
        for (int k = 1; k < LAT; k++) qpipe[k] <= qpipe[k-1];
    end
    assign div_q = qpipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: compare responses against the scoreboard, record new transfers
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e_pop = sb.pop_front();
                check("rsp_id",  64'(bus.rsp_id), 64'(e_pop.id));
                check("rsp_q",   64'(bus.rsp_q),  64'(e_pop.q));
                check("rsp_dbz", 64'(bus.rsp_dbz), 64'(e_pop.dbz));
                check("rsp_lat", 64'(cyc - e_pop.edge_n), 64'(LAT + 1));
            end
        end
        check("rdy_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                e_push.id     = i;
                e_push.dbz    = (bus.req_b[i*32 +: 32] == 32'd0);
                e_push.q      = e_push.dbz ? 32'hFFFF_FFFF
                                           : bus.req_a[i*32 +: 32] / bus.req_b[i*32 +: 32];
                e_push.edge_n = cyc + 1;
                sb.push_back(e_push);
            end
        end
        if (rst) sb.delete();
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Return at the falling edge that follows rising edge number e
    task automatic at_edge(input int e);
        do @(negedge clk); while (cyc < e);
    endtask

    // Called just after a rising edge; returns just after the transfer edge
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        output int t_edge, output int waits);
        bus.req_a[id*32 +: 32] = a;
        bus.req_b[id*32 +: 32] = b;
        bus.req_valid[id]      = 1'b1;
        waits  = 0;
        t_edge = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                sync();
                t_edge = cyc;
                break;
            end
            sync();
            waits++;
        end
        bus.req_valid[id] = 1'b0;
        if (t_edge < 0) check("send_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, w, t0, gidx;

        // Reset state, with requests pending to show grants are held off
        rst           = 1'b1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_valid = '1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready",     64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        check("rst_rsp_q",     64'(bus.rsp_q),     64'd0);
        check("rst_rsp_dbz",   64'(bus.rsp_dbz),   64'd0);
        check("rst_inflight",  64'(inflight),      64'd0);
        check("rst_div_a",     64'(div_a),         64'd0);
        check("rst_div_b",     64'(div_b),         64'd0);
        sync();
        rst           = 1'b0;
        bus.req_valid = '0;

        // Fairness: all four requesting for eight cycles
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*32 +: 32] = 32'((i + 1) * 100);
            bus.req_b[i*32 +: 32] = 32'(i + 3);
        end
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            gidx = -1;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gidx = i;
            check("fair_gnt", 64'(gidx), 64'(k % NREQ));
            sync();
        end
        bus.req_valid = '0;
        t = cyc;
        at_edge(t + 36);
        check("fair_drain_inflight", 64'(inflight), 64'd0);
        check("fair_drain_sb",       64'(sb.size()), 64'd0);
        sync();

        // Single op: requester 1, 100/7
        send(1, 32'd100, 32'd7, t, w);
        at_edge(t);
        check("single_inflight_1", 64'(inflight), 64'd1);
        at_edge(t + 32);
        check("single_early_rsp", 64'(bus.rsp_valid), 64'd0);
        check("single_inflight_2", 64'(inflight), 64'd1);
        at_edge(t + 33);
        check("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("single_rsp_id",    64'(bus.rsp_id),    64'd1);
        check("single_rsp_q",     64'(bus.rsp_q),     64'd14);
        check("single_rsp_dbz",   64'(bus.rsp_dbz),   64'd0);
        at_edge(t + 34);
        check("single_pulse", 64'(bus.rsp_valid), 64'd0);
        check("single_inflight_0", 64'(inflight), 64'd0);
        sync();

        // Divide by zero: requester 3, 5/0
        send(3, 32'd5, 32'd0, t, w);
        at_edge(t + 33);
        check("dbz_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("dbz_rsp_q",     64'(bus.rsp_q),     64'hFFFF_FFFF);
        check("dbz_rsp_dbz",   64'(bus.rsp_dbz),   64'd1);
        check("dbz_rsp_id",    64'(bus.rsp_id),    64'd3);
        at_edge(t + 34);
        sync();

        // Back-to-back stream: requester 2, 1000/i for i = 1..33
        t0 = 0;
        bus.req_a[2*32 +: 32] = 32'd1000;
        for (int k = 1; k <= 33; k++) begin
            bus.req_b[2*32 +: 32] = 32'(k);
            bus.req_valid[2]      = 1'b1;
            @(negedge clk);
            check("strm_rdy", 64'(bus.req_ready[2]), 64'd1);
            if (k == 1) t0 = cyc + 1;
            sync();
        end
        bus.req_valid = '0;
        @(negedge clk);
        check("strm_peak", 64'(inflight), 64'd33);
        for (int j = 0; j < 33; j++) begin
            at_edge(t0 + 33 + j);
            check("strm_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("strm_rsp_q",     64'(bus.rsp_q),     64'(1000 / (j + 1)));
        end
        at_edge(t0 + 67);
        check("strm_end_valid",    64'(bus.rsp_valid), 64'd0);
        check("strm_end_inflight", 64'(inflight),      64'd0);
        sync();

        // Reset mid-flight: ten ops, then one reset cycle at edge t0+15
        bus.req_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.req_a[0 +: 32] = 32'(50 + k);
            bus.req_b[0 +: 32] = 32'(k + 1);
            @(negedge clk);
            if (k == 0) t0 = cyc + 1;
            sync();
        end
        bus.req_valid = '0;
        at_edge(t0 + 13);
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        check("mid_rst_inflight", 64'(inflight),      64'd0);
        check("mid_rst_rsp",      64'(bus.rsp_valid), 64'd0);
        send(1, 32'd77, 32'd7, t, w);
        check("mid_rst_first_gnt", 64'(w), 64'd0);
        for (int j = 1; j <= 32; j++) begin
            at_edge(t + j);
            check("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        at_edge(t + 33);
        check("post_rst_valid", 64'(bus.rsp_valid), 64'd1);
        check("post_rst_id",    64'(bus.rsp_id),    64'd1);
        check("post_rst_q",     64'(bus.rsp_q),     64'd11);
        at_edge(t + 34);
        sync();

        // Idle hold
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("idle", {55'd0, bus.rsp_valid, bus.req_ready, inflight}, 64'd0);
        end
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
